// File: rtl/cacheline_burst_adapter_if.sv
// Bundles the cache-side line port and the DRAM-side burst port of the adapter.
// The adapter uses the slave view; the cache/DRAM side uses the master view.
interface cacheline_burst_adapter_if #(
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_WIDTH = 32
);
  localparam int LINE_WIDTH = BEAT_WIDTH * BURST_LEN;

  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic [ADDR_WIDTH-1:0] burst_address;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic                  burst_read;
  logic                  burst_write;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic                  burst_resp;

  modport slave (
    input  pmem_address, pmem_wdata, pmem_read, pmem_write, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_address, burst_wdata, burst_read, burst_write
  );

  modport master (
    output pmem_address, pmem_wdata, pmem_read, pmem_write, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_address, burst_wdata, burst_read, burst_write
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts single-handshake full-line pmem reads/writes into fixed-length
// bursts of beats on the DRAM side, buffering exactly one line.
module cacheline_burst_adapter #(
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  cacheline_burst_adapter_if.slave bus
);
  localparam int LINE_WIDTH = BEAT_WIDTH * BURST_LEN;
  localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFF_W      = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_next;
  logic [LINE_WIDTH-1:0] line_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [BEAT_WIDTH-1:0] wdata_r;
  logic                  pmem_resp_r;
  logic                  burst_read_r;
  logic                  burst_write_r;

  assign cnt_next = cnt_r + CNT_W'(1);

  // Burst sequencer: request latch, beat counting, line assembly and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      line_r        <= '0;
      addr_r        <= '0;
      wdata_r       <= '0;
      pmem_resp_r   <= 1'b0;
      burst_read_r  <= 1'b0;
      burst_write_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pmem_resp_r <= 1'b0;
          // A simultaneous read and write request resolves to the write.
          if (bus.pmem_write) begin
            addr_r        <= bus.pmem_address & ALIGN_MASK;
            line_r        <= bus.pmem_wdata;
            wdata_r       <= bus.pmem_wdata[BEAT_WIDTH-1:0];
            cnt_r         <= '0;
            burst_write_r <= 1'b1;
            state_r       <= WR_BURST;
          end else if (bus.pmem_read) begin
            addr_r       <= bus.pmem_address & ALIGN_MASK;
            cnt_r        <= '0;
            burst_read_r <= 1'b1;
            state_r      <= RD_BURST;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_BURST: begin
          if (bus.burst_resp) begin
            line_r[int'(cnt_r) * BEAT_WIDTH +: BEAT_WIDTH] <= bus.burst_rdata;
            if (cnt_r == LAST_BEAT) begin
              cnt_r        <= '0;
              burst_read_r <= 1'b0;
              pmem_resp_r  <= 1'b1;
              state_r      <= DONE;
            end else begin
              cnt_r <= cnt_next;
            end
          end else begin
            state_r <= RD_BURST;
          end
        end
        WR_BURST: begin
          if (bus.burst_resp) begin
            if (cnt_r == LAST_BEAT) begin
              cnt_r         <= '0;
              burst_write_r <= 1'b0;
              pmem_resp_r   <= 1'b1;
              state_r       <= DONE;
            end else begin
              cnt_r   <= cnt_next;
              wdata_r <= line_r[int'(cnt_next) * BEAT_WIDTH +: BEAT_WIDTH];
            end
          end else begin
            state_r <= WR_BURST;
          end
        end
        DONE: begin
          pmem_resp_r   <= 1'b0;
          burst_read_r  <= 1'b0;
          burst_write_r <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          cnt_r         <= '0;
          pmem_resp_r   <= 1'b0;
          burst_read_r  <= 1'b0;
          burst_write_r <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign bus.pmem_rdata    = line_r;
  assign bus.pmem_resp     = pmem_resp_r;
  assign bus.burst_address = addr_r;
  assign bus.burst_wdata   = wdata_r;
  assign bus.burst_read    = burst_read_r;
  assign bus.burst_write   = burst_write_r;
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomized self-checking bench for cacheline_burst_adapter: each line
// transaction is checked cycle by cycle against the expected burst protocol.
module tb_cacheline_burst_adapter;
  localparam int BW = 64;
  localparam int BL = 4;
  localparam int AW = 32;
  localparam int LW = BW * BL;
  localparam logic [AW-1:0] ALIGN = 32'hFFFF_FFE0;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [LW-1:0] model_rdata;
  bit   gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  cacheline_burst_adapter_if #(.BEAT_WIDTH(BW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) bus ();

  cacheline_burst_adapter #(.BEAT_WIDTH(BW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_value(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One full line transaction. For reads, 'line' supplies the DRAM beats
  // (beat i = line[i*BW +: BW]); for writes it is the line to be written.
  // Either way the cache must see 'line' on pmem_rdata at completion.
  // mode: 0 back-to-back beats, 1 fixed gap pattern, 2 random gaps.
  task automatic run_txn(input bit is_wr, input bit both, input logic [AW-1:0] addr,
                         input logic [LW-1:0] line, input int mode, input bit spurious);
    int beat = 0;
    int cyc  = 0;
    bit r;
    bus.pmem_address = addr;
    bus.pmem_wdata   = is_wr ? line : rand_line();
    bus.pmem_read    = !is_wr || both;
    bus.pmem_write   = is_wr;
    bus.burst_resp   = 1'b0;
    step();
    while (beat < BL) begin
      check_value("burst_read", LW'(bus.burst_read), LW'(!is_wr));
      check_value("burst_write", LW'(bus.burst_write), LW'(is_wr));
      check_value("burst_address", LW'(bus.burst_address), LW'(addr & ALIGN));
      check_value("pmem_resp_early", LW'(bus.pmem_resp), '0);
      if (is_wr) check_value("burst_wdata", LW'(bus.burst_wdata), LW'(line[beat*BW +: BW]));
      case (mode)
        0:       r = 1'b1;
        1:       r = gap_pat[cyc % 7];
        default: r = (cyc > 40) || ($urandom_range(0, 2) != 0);
      endcase
      bus.burst_resp  = r;
      bus.burst_rdata = (r && !is_wr) ? line[beat*BW +: BW] : {$urandom, $urandom};
      if (r) beat++;
      cyc++;
      step();
    end
    check_value("pmem_resp_done", LW'(bus.pmem_resp), LW'(1'b1));
    check_value("burst_read_done", LW'(bus.burst_read), '0);
    check_value("burst_write_done", LW'(bus.burst_write), '0);
    check_value("pmem_rdata_done", bus.pmem_rdata, line);
    model_rdata = line;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.burst_resp  = spurious;
    bus.burst_rdata = {$urandom, $urandom};
    step();
    check_value("pmem_resp_idle", LW'(bus.pmem_resp), '0);
    check_value("pmem_rdata_idle", bus.pmem_rdata, model_rdata);
    check_value("burst_read_idle", LW'(bus.burst_read | bus.burst_write), '0);
    if (spurious) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = {$urandom, $urandom};
      step();
      check_value("spurious_resp", LW'(bus.pmem_resp), '0);
      check_value("spurious_rdata", bus.pmem_rdata, model_rdata);
      check_value("spurious_burst", LW'(bus.burst_read | bus.burst_write), '0);
    end
    bus.burst_resp = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_pmem_resp", LW'(bus.pmem_resp), '0);
    check_value("rst_burst_rw", LW'({bus.burst_read, bus.burst_write}), '0);
    check_value("rst_pmem_rdata", bus.pmem_rdata, '0);
    check_value("rst_burst_address", LW'(bus.burst_address), '0);
    rst = 1'b0;
    step();

    // Back-to-back read beats; address 0x1234 must align to 0x1220.
    run_txn(1'b0, 1'b0, 32'h0000_1234,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_8008,
            {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 0, 1'b0);
    run_txn(1'b0, 1'b0, $urandom, rand_line(), 1, 1'b0);
    run_txn(1'b1, 1'b1, $urandom, rand_line(), 2, 1'b0);

    // Asynchronous reset after two read beats.
    bus.pmem_address = 32'hABCD_0040;
    bus.pmem_read    = 1'b1;
    bus.burst_resp   = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      step();
    end
    bus.burst_resp = 1'b0;
    rst = 1'b1;
    #1;
    check_value("arst_burst_read", LW'(bus.burst_read), '0);
    check_value("arst_pmem_rdata", bus.pmem_rdata, '0);
    check_value("arst_burst_address", LW'(bus.burst_address), '0);
    check_value("arst_pmem_resp", LW'(bus.pmem_resp), '0);
    bus.pmem_read = 1'b0;
    #2;
    rst = 1'b0;
    step();
    check_value("arst_no_resp", LW'(bus.pmem_resp), '0);
    run_txn(1'b0, 1'b0, 32'hABCD_0040, rand_line(), 0, 1'b0);

    // Spurious beat responses around completion, then read/write back to back.
    run_txn(1'b0, 1'b0, $urandom, rand_line(), 2, 1'b1);
    run_txn(1'b1, 1'b0, $urandom, rand_line(), 1, 1'b1);
    run_txn(1'b0, 1'b0, $urandom, rand_line(), 0, 1'b0);
    run_txn(1'b1, 1'b0, $urandom, rand_line(), 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom,
              rand_line(), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
